// File: rtl/boxcar_decim_pkg.sv
// Shared types and sizing helpers for the boxcar decimator controller.
package boxcar_decim_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned LOG2_MAX_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      RUN
   } state_t;

   // Accumulator width that holds a full block of max length without overflow.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned log2_max);
      return data_width + log2_max;
   endfunction

endpackage

// File: rtl/boxcar_decim_if.sv
// Sample stream in and averaged stream out of the boxcar decimator.
interface boxcar_decim_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                         sync;
   logic signed [DATA_WIDTH-1:0] din;
   logic                         din_valid;
   logic signed [DATA_WIDTH-1:0] dout;
   logic                         dout_valid;

   modport master (output sync, din, din_valid, input dout, dout_valid);
   modport slave  (input sync, din, din_valid, output dout, dout_valid);
endinterface

// File: rtl/boxcar_decim_acc.sv
// Block accumulator and arithmetic-shift averaging datapath.
module boxcar_decim_acc
   import boxcar_decim_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned LOG2_MAX   = LOG2_MAX_DEF,
   localparam int unsigned CFG_W     = $clog2(LOG2_MAX + 1)
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         clear,
   input  logic                         load,
   input  logic                         add,
   input  logic [CFG_W-1:0]             shift,
   input  logic signed [DATA_WIDTH-1:0] din,
   output logic signed [DATA_WIDTH-1:0] result_c
);
   localparam int unsigned ACC_W = acc_width(DATA_WIDTH, LOG2_MAX);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] base_c;
   logic signed [ACC_W-1:0] sum_c;
   logic signed [ACC_W-1:0] shifted_c;

   // Sum including the current sample; a load starts from zero instead of acc.
   always_comb begin
      base_c    = load ? '0 : acc;
      sum_c     = base_c + ACC_W'(din);
      shifted_c = sum_c >>> shift;
      result_c  = DATA_WIDTH'(shifted_c);
   end

   // Accumulator register; clear wins so a dumping sample leaves acc empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (load || add) begin
         acc <= sum_c;
      end
   end

endmodule

// File: rtl/boxcar_decim_ctrl.sv
// Accumulate-and-dump boxcar decimator: FSM, config shadowing and counters.
module boxcar_decim_ctrl
   import boxcar_decim_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned LOG2_MAX   = LOG2_MAX_DEF,
   localparam int unsigned CFG_W     = $clog2(LOG2_MAX + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic [CFG_W-1:0] cfg_log2,
   input  logic             cfg_update,
   boxcar_decim_if.slave    bus,
   output logic [CFG_W-1:0] cfg_active,
   output logic             cfg_error,
   output logic [31:0]      block_cnt
);
   localparam int unsigned CNT_W = LOG2_MAX;

   state_t                       state;
   logic [CNT_W-1:0]             cnt;
   logic [CFG_W-1:0]             pending;

   logic                         over_c;
   logic [CFG_W-1:0]             pending_nxt_c;
   logic [CFG_W-1:0]             eff_log2_c;
   logic [CNT_W-1:0]             eff_cnt_c;
   logic [CNT_W:0]               span_c;
   logic [CNT_W-1:0]             last_idx_c;
   logic                         take_c;
   logic                         start_c;
   logic                         last_c;
   logic                         clear_c;
   logic signed [DATA_WIDTH-1:0] result_c;

   // Sample qualification: accept, (re)start a block, or close one.
   always_comb begin
      over_c        = 32'(cfg_log2) > LOG2_MAX;
      pending_nxt_c = cfg_update ? (over_c ? CFG_W'(LOG2_MAX) : cfg_log2) : pending;
      take_c        = enable && bus.din_valid &&
                      ((state == RUN) || ((state == ALIGN) && bus.sync));
      start_c       = take_c && bus.sync && ((state == ALIGN) || (cnt != '0));
      eff_log2_c    = start_c ? pending_nxt_c : cfg_active;
      eff_cnt_c     = start_c ? '0 : cnt;
      span_c        = (CNT_W + 1)'(1) << eff_log2_c;
      last_idx_c    = CNT_W'(span_c - (CNT_W + 1)'(1));
      last_c        = take_c && (eff_cnt_c == last_idx_c);
      clear_c       = !enable || last_c || ((state != RUN) && !start_c);
   end

   boxcar_decim_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG2_MAX   (LOG2_MAX)
   ) u_acc (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (clear_c),
      .load     (start_c),
      .add      (take_c && !start_c),
      .shift    (eff_log2_c),
      .din      (bus.din),
      .result_c (result_c)
   );

   // FSM, sample counter, block counter and registered output sample.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         block_cnt      <= '0;
      end else begin
         bus.dout_valid <= last_c;
         if (last_c) begin
            bus.dout  <= result_c;
            block_cnt <= block_cnt + 32'd1;
         end
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            if (last_c) begin
               cnt <= '0;
            end else if (start_c) begin
               cnt <= CNT_W'(1);
            end else if (take_c) begin
               cnt <= cnt + CNT_W'(1);
            end
            case (state)
               IDLE: begin
                  state     <= ALIGN;
                  block_cnt <= '0;
               end
               ALIGN: begin
                  if (start_c) begin
                     state <= RUN;
                  end
               end
               RUN:     state <= RUN;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Config shadow: pending follows updates, active picks it up at block boundaries.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending    <= '0;
         cfg_active <= '0;
         cfg_error  <= 1'b0;
      end else begin
         pending <= pending_nxt_c;
         if (cfg_update) begin
            cfg_error <= over_c;
         end
         if ((state != RUN) || last_c || start_c) begin
            cfg_active <= pending_nxt_c;
         end
      end
   end

endmodule
